// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM access port.
package ppu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned T_W    = 14;

    localparam logic [15:0] REG_CTRL     = 16'h2000;
    localparam logic [15:0] REG_STATUS   = 16'h2002;
    localparam logic [15:0] REG_ADDR     = 16'h2006;
    localparam logic [15:0] REG_DATA     = 16'h2007;
    localparam logic [15:0] PALETTE_BASE = 16'h3F00;

    typedef enum logic [1:0] {IDLE, WRITE, FETCH, FILL} state_e;

    typedef enum logic [1:0] {OP_NONE, OP_WR_DATA, OP_RD_DATA, OP_WR_ADDR} op_e;

    typedef struct packed {
        logic              valid;
        op_e               op;
        logic [DATA_W-1:0] data;
    } pend_t;

endpackage

// File: rtl/ppu_addr_latch.sv
// $2006 two-write address latch: temporary address t and write toggle w.
module ppu_addr_latch
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              clr_w,
    input  logic [DATA_W-1:0] data,
    output logic              load_c,
    output logic [T_W-1:0]    addr_c
);

    logic [T_W-1:0] t;
    logic [T_W-1:0] t_next;
    logic           w;

    // First write sets the high bits, second sets the low byte and commits.
    always_comb begin
        t_next = t;
        if (wr_en) begin
            if (!w) t_next = T_W'({data[5:0], t[7:0]});
            else    t_next = T_W'({t[T_W-1:8], data});
        end
    end

    assign load_c = wr_en && w;
    assign addr_c = t_next;

    // A $2002 read in the same cycle as a deferred $2006 write wins on w.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t <= '0;
            w <= 1'b0;
        end else begin
            t <= t_next;
            if (wr_en) w <= ~w;
            if (clr_w) w <= 1'b0;
        end
    end

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-side $2000/$2002/$2006/$2007 port into PPU VRAM with a one-entry pending slot.
// Optional feature: PPU_PALETTE_READ_BYPASS_EN returns palette bytes directly on $2007 reads.
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned ROW_INC = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cpu_address,
    input  logic [DATA_W-1:0] cpu_data_in,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic [15:0]       vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              busy,
    output logic              overrun
);

    state_e            state;
    state_e            state_next;
    op_e               new_op;
    op_e               exec_op;
    logic [DATA_W-1:0] exec_data;
    pend_t             pend;
    pend_t             pend_next;
    logic              drop;
    logic              ctrl_wr;
    logic              status_rd;
    logic              load_addr;
    logic [T_W-1:0]    t_addr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] inc;
    logic [DATA_W-1:0] read_buf;
    logic              inc_sel;

    assign ctrl_wr   = cpu_wr && (cpu_address == REG_CTRL);
    assign status_rd = cpu_rd && !cpu_wr && (cpu_address == REG_STATUS);
    assign inc       = inc_sel ? ADDR_W'(ROW_INC) : ADDR_W'(1);
    assign vram_addr = 16'(addr);

    // Accesses that go through the FSM / pending slot; a write beats a read.
    always_comb begin
        new_op = OP_NONE;
        if (cpu_wr) begin
            if (cpu_address == REG_DATA)      new_op = OP_WR_DATA;
            else if (cpu_address == REG_ADDR) new_op = OP_WR_ADDR;
        end else if (cpu_rd && (cpu_address == REG_DATA)) begin
            new_op = OP_RD_DATA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // IDLE services the pending slot first; any access arriving that cycle is dropped.
    always_comb begin
        state_next = state;
        exec_op    = OP_NONE;
        exec_data  = cpu_data_in;
        pend_next  = pend;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (pend.valid) begin
                    exec_op   = pend.op;
                    exec_data = pend.data;
                    pend_next = '0;
                    drop      = (new_op != OP_NONE);
                end else begin
                    exec_op = new_op;
                end
                if (exec_op == OP_WR_DATA)      state_next = WRITE;
                else if (exec_op == OP_RD_DATA) state_next = FETCH;
            end
            WRITE:   state_next = IDLE;
            FETCH:   state_next = FILL;
            FILL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if ((state != IDLE) && (new_op != OP_NONE)) begin
            if (pend.valid) begin
                drop = 1'b1;
            end else begin
                pend_next.valid = 1'b1;
                pend_next.op    = new_op;
                pend_next.data  = cpu_data_in;
            end
        end
    end

    ppu_addr_latch u_addr_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (exec_op == OP_WR_ADDR),
        .clr_w   (status_rd),
        .data    (exec_data),
        .load_c  (load_addr),
        .addr_c  (t_addr)
    );

`ifdef PPU_PALETTE_READ_BYPASS_EN
    logic in_palette;
    assign in_palette = (vram_addr[15:8] == PALETTE_BASE[15:8]);
`endif

    // Address loads happen only in IDLE, increments only in WRITE/FILL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= '0;
            inc_sel      <= 1'b0;
            read_buf     <= '0;
            cpu_data_out <= '0;
            vram_wdata   <= '0;
            vram_we      <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            pend         <= '0;
        end else begin
            pend    <= pend_next;
            vram_we <= (state_next == WRITE);
            busy    <= (state_next != IDLE);
            if (drop)                   overrun      <= 1'b1;
            if (ctrl_wr)                inc_sel      <= cpu_data_in[2];
            if (exec_op == OP_WR_DATA)  vram_wdata   <= exec_data;
            if (exec_op == OP_RD_DATA)  cpu_data_out <= read_buf;
            if (load_addr)              addr         <= ADDR_W'(t_addr);
            if ((state == WRITE) || (state == FILL)) addr <= addr + inc;
            if (state == FILL) begin
                read_buf <= vram_rdata;
`ifdef PPU_PALETTE_READ_BYPASS_EN
                if (in_palette) cpu_data_out <= vram_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed scoreboard bench for ppu_vram_port with a behavioural VRAM.
module tb_ppu_vram_port;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_data_out;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic        busy;
    logic        overrun;

    logic [7:0]  mem [0:16383];
    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] m_addr;
    logic        m_inc;
    logic [7:0]  m_buf;

    ppu_vram_port dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_address  (cpu_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_data_out (cpu_data_out),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_we      (vram_we),
        .vram_rdata   (vram_rdata),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // VRAM: synchronous read one cycle after address, write when vram_we is seen.
    always @(posedge clk) vram_rdata <= mem[vram_addr[13:0]];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && vram_we === 1'b1) begin
            n_checks++;
            assert (wr_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h data %h expected none", vram_addr, vram_wdata);
            end
            if (wr_q.size() != 0) begin
                wr_t e;
                e = wr_q.pop_front();
                mem[vram_addr[13:0]] = vram_wdata;
                check("wr_addr", vram_addr, e.addr);
                check("wr_data", {8'h00, vram_wdata}, {8'h00, e.data});
            end
        end
    end

    function automatic logic [13:0] step(input logic [13:0] a);
        return a + (m_inc ? 14'd32 : 14'd1);
    endfunction

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_addr = '0;
        m_inc  = 1'b0;
        m_buf  = '0;
    endtask

    task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_address = a;
        cpu_data_in = d;
        cpu_wr      = 1'b1;
        @(negedge clk);
        cpu_wr      = 1'b0;
    endtask

    task automatic reg_rd(input logic [15:0] a);
        @(negedge clk);
        cpu_address = a;
        cpu_rd      = 1'b1;
        @(negedge clk);
        cpu_rd      = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] a);
        reg_wr(16'h2006, a[15:8]);
        reg_wr(16'h2006, a[7:0]);
        m_addr = a[13:0];
    endtask

    task automatic vwrite(input logic [7:0] d);
        wr_q.push_back({2'b00, m_addr, d});
        m_addr = step(m_addr);
        reg_wr(16'h2007, d);
        settle();
    endtask

    task automatic vread();
        logic [7:0] exp;
        exp = m_buf;
`ifdef PPU_PALETTE_READ_BYPASS_EN
        if (m_addr[13:8] == 6'h3F) exp = mem[m_addr];
`endif
        rd_q.push_back(exp);
        m_buf  = mem[m_addr];
        m_addr = step(m_addr);
        reg_rd(16'h2007);
        settle();
        check("rd_data", {8'h00, cpu_data_out}, {8'h00, rd_q.pop_front()});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        reset_n     = 1'b0;
        cpu_address = '0;
        cpu_data_in = '0;
        cpu_wr      = 1'b0;
        cpu_rd      = 1'b0;
        m_addr      = '0;
        m_inc       = 1'b0;
        m_buf       = '0;

        repeat (2) @(negedge clk);
        check("rst_data_out", {8'h00, cpu_data_out}, 16'h0000);
        check("rst_vram_addr", vram_addr, 16'h0000);
        check("rst_flags", {12'h000, vram_we, busy, overrun, 1'b0}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Plain write through $2006/$2007
        set_addr(16'h2108);
        vwrite(8'h5A);
        check("addr_after_write", vram_addr, 16'h2109);

        // Row increment
        reg_wr(16'h2000, 8'h04);
        m_inc = 1'b1;
        set_addr(16'h23C0);
        vwrite(8'hA1);
        vwrite(8'hA2);
        check("addr_row_inc", vram_addr, 16'h2400);

        // Wrap-around
        set_addr(16'h3FF0);
        vwrite(8'hB1);
        check("wrap_row", vram_addr, 16'h0010);
        reg_wr(16'h2000, 8'h00);
        m_inc = 1'b0;
        set_addr(16'h3FFF);
        vwrite(8'hB2);
        check("wrap_one", vram_addr, 16'h0000);

        // Buffered reads
        do_reset();
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h00;
        vread();
        vread();
        vread();
        check("addr_after_reads", vram_addr, 16'h0003);

        // Palette region reads
        mem[14'h3F00] = 8'h6C;
        mem[14'h3F01] = 8'h00;
        set_addr(16'h3F00);
        vread();
        vread();

        // $2002 read resets the write toggle
        reg_wr(16'h2006, 8'h3F);
        reg_rd(16'h2002);
        set_addr(16'h1000);
        check("toggle_clear", vram_addr, 16'h1000);

        // $2006 write deferred behind an in-flight $2007 write
        reg_wr(16'h2006, 8'h05);
        wr_q.push_back({16'h1000, 8'h77});
        @(negedge clk);
        cpu_address = 16'h2007;
        cpu_data_in = 8'h77;
        cpu_wr      = 1'b1;
        @(negedge clk);
        cpu_address = 16'h2006;
        cpu_data_in = 8'h20;
        @(negedge clk);
        cpu_wr = 1'b0;
        settle();
        m_addr = 14'h0520;
        check("deferred_addr", vram_addr, 16'h0520);
        check("no_overrun_yet", {15'h0000, overrun}, 16'h0000);

        // Three back-to-back writes: third is dropped
        set_addr(16'h0200);
        wr_q.push_back({16'h0200, 8'hC1});
        wr_q.push_back({16'h0201, 8'hC2});
        @(negedge clk);
        cpu_address = 16'h2007;
        cpu_data_in = 8'hC1;
        cpu_wr      = 1'b1;
        @(negedge clk);
        cpu_data_in = 8'hC2;
        @(negedge clk);
        cpu_data_in = 8'hC3;
        @(negedge clk);
        cpu_wr = 1'b0;
        settle();
        check("overrun_set", {15'h0000, overrun}, 16'h0001);
        check("addr_after_drop", vram_addr, 16'h0202);
        check("idle_after_drop", {15'h0000, busy}, 16'h0000);

        // Reset during WRITE aborts the operation
        do_reset();
        set_addr(16'h0300);
        wr_q.push_back({16'h0300, 8'h99});
        reg_wr(16'h2007, 8'h99);
        #1 reset_n = 1'b0;
        #1;
        check("abort_we", {15'h0000, vram_we}, 16'h0000);
        check("abort_outputs", {vram_wdata, cpu_data_out}, 16'h0000);
        check("abort_addr", vram_addr, 16'h0000);
        check("abort_flags", {14'h0000, busy, overrun}, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        settle();
        check("no_write_after_reset", vram_addr, 16'h0000);
        check("wr_queue_empty", 16'(wr_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_vram_port.md
PPU_VRAM_PORT -- requirements
Module: ppu_vram_port

Interface
REQ-001 Parameter: ADDR_W, 14, VRAM address width; the address wraps modulo 2^ADDR_W.
REQ-002 Parameter: ROW_INC, 32, increment used when PPUCTRL bit 2 is set.
REQ-003 Port: clk, in, 1, single clock; all state changes on the rising edge.
REQ-004 Port: reset_n, in, 1, asynchronous, active-low reset.
REQ-005 Port: cpu_address, in, 16, CPU bus address.
REQ-006 Port: cpu_data_in, in, 8, CPU write data.
REQ-007 Port: cpu_wr, in, 1, one-cycle CPU write strobe.
REQ-008 Port: cpu_rd, in, 1, one-cycle CPU read strobe.
REQ-009 Port: cpu_data_out, out, 8, registered $2007 read data.
REQ-010 Port: vram_addr, out, 16, VRAM address; bits above ADDR_W are zero.
REQ-011 Port: vram_wdata, out, 8, VRAM write data.
REQ-012 Port: vram_we, out, 1, one-cycle VRAM write enable.
REQ-013 Port: vram_rdata, in, 8, VRAM read data; valid one cycle after vram_addr is presented.
REQ-014 Port: busy, out, 1, high when state is not IDLE.
REQ-015 Port: overrun, out, 1, sticky flag for a dropped access; cleared only by reset.

Function
REQ-016 A write to $2000 SHALL capture bit 2 as inc_sel: 0 selects +1, 1 selects +ROW_INC.
REQ-017 A read of $2002 SHALL clear the write toggle w; cpu_data_out SHALL be unaffected.
REQ-018 Writes to $2006 SHALL behave as follows:
- w=0: load t[13:8] from data[5:0]; bit 14 and above cleared; w becomes 1.
- w=1: load t[7:0]; copy t into addr; w becomes 0.
REQ-019 States: IDLE, WRITE, FETCH, FILL. IDLE SHALL accept a $2007 access the cycle its strobe is sampled.
REQ-020 $2007 write: IDLE->WRITE. In WRITE, vram_we=1, vram_wdata=captured byte, vram_addr=addr. Then addr += inc and the state returns to IDLE.
REQ-021 $2007 read: on acceptance, cpu_data_out SHALL load read_buf (valid the next cycle). Then IDLE->FETCH, with vram_addr=addr for one cycle. Then FILL: read_buf <= vram_rdata, addr += inc, return to IDLE.
REQ-022 A $2007 access arriving while busy SHALL go into a one-entry pending slot. The slot is serviced on the cycle after return to IDLE. If the slot is already full, the access is dropped and overrun is set.
REQ-023 $2006 writes arriving while busy SHALL update t/addr only after the current operation's increment completes. They use the same pending slot and the same drop rule.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W: $3FFF+1 becomes $0000, and $3FF0+32 becomes $0010.
REQ-025 vram_we SHALL be 0 in every state other than WRITE.
REQ-026 Simultaneous cpu_wr and cpu_rd SHALL execute the write only.

Reset
REQ-027 While reset_n=0, the following SHALL be zero: addr, t, w, inc_sel, read_buf, cpu_data_out, vram_we, busy, overrun, and the pending slot. State SHALL be IDLE.
REQ-028 Reset asserted mid-operation SHALL abort it immediately, with no VRAM write issued after deassertion.

Configuration
REQ-029 Macro PPU_PALETTE_READ_BYPASS_EN.
- Defined: a $2007 read with addr in $3F00-$3FFF SHALL return that palette byte in cpu_data_out once FILL completes, two cycles later. read_buf SHALL still be filled from that fetch.
- Undefined: all addresses use buffered behaviour.

Structure
REQ-030 Shared package ppu_pkg SHALL hold:
- the state enum;
- register address constants $2000, $2002, $2006, $2007;
- the palette base constant $3F00.
REQ-031 The $2006 high/low latch (t, w) SHALL be the sub-module ppu_addr_latch.

Verification
REQ-032 $2006←$21, $2006←$08, $2007←$5A with inc_sel=0 -> one vram_we pulse, addr $2108, wdata $5A; addr becomes $2109.
REQ-033 $2000←$04, then two $2007 writes from $23C0 -> writes at $23C0 and $23E0; final addr $2400.
REQ-034 VRAM[$0000]=$11, [$0001]=$22, addr $0000, three $2007 reads:
- returned data: $00, $11, $22;
- final addr: $0003.
REQ-035 Three back-to-back $2007 writes, one cycle apart, while busy -> the first two complete in order; the third is dropped; overrun=1.
REQ-036 Single $2006 write of $3F, then $2002 read, then $2006←$10, $2006←$00 -> addr $1000.
REQ-037 reset_n low during WRITE -> vram_we=0 within the same cycle; all outputs zero; no write after release.
